// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  fifo_arb_pkg : shared FSM state type and burst-length helpers
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   function automatic int len_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

   // A zero length still moves one word; oversize requests are cut to max_burst.
   function automatic int clamp_len(input int len, input int max_burst);
      if (len < 1) begin
         return 1;
      end
      if (len > max_burst) begin
         return max_burst;
      end
      return len;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_picker.sv
// ============================================================================
//  rr_picker : combinational round-robin priority encoder
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
   parameter  int NumReq   = 4,
   localparam int IdxWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   req_i,
   input  logic [IdxWidth-1:0] last_i,
   output logic [NumReq-1:0]   grant_o,
   output logic [IdxWidth-1:0] idx_o,
   output logic                any_o
);

   int cand;

   // Scan starts just after last_i so the previous winner has lowest priority.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = 0;
      for (int off = 1; off <= NumReq; off++) begin
         cand = int'(last_i) + off;
         if (cand >= NumReq) begin
            cand = cand - NumReq;
         end
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = IdxWidth'(cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
//  fifo_write_arbiter : round-robin burst arbiter for one FIFO write port
//  Revision           : 1.0
// ============================================================================
`default_nettype none

module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NumReq    = 4,
   parameter  int DataWidth = 32,
   parameter  int MaxBurst  = 16,
   localparam int LenWidth  = len_width(MaxBurst),
   localparam int IdxWidth  = $clog2(NumReq)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq*LenWidth-1:0]    burst_len_i,
   input  logic [NumReq*DataWidth-1:0]   data_i,
   output logic [NumReq-1:0]             ack_o,
   output logic [NumReq-1:0]             grant_o,
   output logic                          busy_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_write_en_o,
   output logic [DataWidth-1:0]          fifo_data_o
);

   arb_state_e             state_q, state_d;
   logic [NumReq-1:0]      grant_q, grant_d;
   logic [IdxWidth-1:0]    idx_q, idx_d;
   logic [IdxWidth-1:0]    last_q, last_d;
   logic [LenWidth-1:0]    remaining_q, remaining_d;

   logic [NumReq-1:0]      pick_grant;
   logic [IdxWidth-1:0]    pick_idx;
   logic                   pick_any;
   logic [LenWidth-1:0]    pick_len_raw;
   logic [LenWidth-1:0]    pick_len;
   logic [DataWidth-1:0]   sel_data;
   logic                   sel_req;
   logic                   busy;
   logic                   write_en;

   rr_picker #(
      .NumReq (NumReq)
   ) u_picker (
      .req_i   (req_i),
      .last_i  (last_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   always_comb begin
      pick_len_raw = '0;
      sel_data     = '0;
      sel_req      = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         if (pick_idx == IdxWidth'(k)) begin
            pick_len_raw = burst_len_i[k*LenWidth +: LenWidth];
         end
         if (idx_q == IdxWidth'(k)) begin
            sel_data = data_i[k*DataWidth +: DataWidth];
            sel_req  = req_i[k];
         end
      end
   end

   assign pick_len = LenWidth'(clamp_len(int'(pick_len_raw), MaxBurst));

   // Write strobe stays combinational so a full FIFO blocks the same cycle.
   assign busy     = (state_q == BURST);
   assign write_en = busy & sel_req & ~fifo_full_i & ~rst_i;

   assign fifo_write_en_o = write_en;
   assign fifo_data_o     = write_en ? sel_data : '0;
   assign ack_o           = write_en ? grant_q  : '0;
   assign grant_o         = grant_q;
   assign busy_o          = busy;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      idx_d       = idx_q;
      last_d      = last_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d     = BURST;
               grant_d     = pick_grant;
               idx_d       = pick_idx;
               remaining_d = pick_len;
            end
         end
         BURST: begin
            if (!sel_req) begin
               // Requester withdrew: abandon the rest of the burst.
               state_d     = IDLE;
               grant_d     = '0;
               last_d      = idx_q;
               remaining_d = '0;
            end else if (!fifo_full_i) begin
               remaining_d = remaining_q - LenWidth'(1);
               if (remaining_q == LenWidth'(1)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  last_d  = idx_q;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            remaining_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         idx_q       <= '0;
         last_q      <= IdxWidth'(NumReq - 1);
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
//  tb_fifo_write_arbiter : directed self-checking bench for fifo_write_arbiter
//  Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int MB = 16;
   localparam int LW = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req;
   logic [NR*LW-1:0] blen;
   logic [NR*DW-1:0] data;
   logic [NR-1:0]  ack;
   logic [NR-1:0]  grant;
   logic           busy;
   logic           full;
   logic           we;
   logic [DW-1:0]  wdata;

   int n_chk  = 0;
   int n_fail = 0;
   int n_wr;
   int n_idle;
   int wr_by [NR];
   int glog  [16];
   int glog_n;
   logic [NR-1:0] prev_grant;

   always #5 clk = ~clk;

   fifo_write_arbiter #(
      .NumReq    (NR),
      .DataWidth (DW),
      .MaxBurst  (MB)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_i           (req),
      .burst_len_i     (blen),
      .data_i          (data),
      .ack_o           (ack),
      .grant_o         (grant),
      .busy_o          (busy),
      .fifo_full_i     (full),
      .fifo_write_en_o (we),
      .fifo_data_o     (wdata)
   );

   function automatic logic [DW-1:0] dword(input int k);
      return 32'hC0DE_0000 + 32'(k) * 32'h0000_0111;
   endfunction

   function automatic int oh_idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_len(input int k, input int v);
      blen[k*LW +: LW] = LW'(v);
   endtask

   task automatic clear_stats();
      n_wr = 0;
      n_idle = 0;
      glog_n = 0;
      prev_grant = '0;
      for (int i = 0; i < NR; i++) wr_by[i] = 0;
   endtask

   // Samples one cycle's outputs, accumulates statistics, waits for the next negedge.
   task automatic step();
      int k;
      #1;
      check("we_while_full", {63'd0, we & full}, 64'd0);
      check("ack_onehot", {63'd0, $countones(ack) <= 1}, 64'd1);
      if (rst) check("rst_quiet", {59'd0, we, ack}, 64'd0);
      if (we) begin
         k = oh_idx(ack);
         check("ack_on_write", 64'($countones(ack)), 64'd1);
         check("wdata", 64'(wdata), 64'(dword(k)));
         n_wr++;
         wr_by[k]++;
      end else begin
         check("wdata_zero", 64'(wdata), 64'd0);
      end
      if (grant != '0 && prev_grant == '0 && glog_n < 16) begin
         glog[glog_n] = oh_idx(grant);
         glog_n++;
      end
      if (!busy) n_idle++;
      prev_grant = grant;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      full = 1'b0;
      blen = '0;
      @(negedge clk);
      #1;
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_we", {63'd0, we}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      full = 1'b0;
      blen = '0;
      for (int k = 0; k < NR; k++) data[k*DW +: DW] = dword(k);

      // Single requester, three-word burst
      do_reset();
      set_len(0, 3);
      req = 4'b0001;
      #1;
      check("t1_c0_grant", 64'(grant), 64'd0);
      check("t1_c0_we", {63'd0, we}, 64'd0);
      step();
      #1;
      check("t1_c1_grant", 64'(grant), 64'b0001);
      check("t1_c1_we", {63'd0, we}, 64'd1);
      repeat (3) step();
      #1;
      check("t1_c4_busy", {63'd0, busy}, 64'd0);
      check("t1_c4_grant", 64'(grant), 64'd0);
      check("t1_writes", 64'(wr_by[0]), 64'd3);
      req = '0;
      step();

      // All four requesting, length 2 each: round-robin rotation
      do_reset();
      for (int k = 0; k < NR; k++) set_len(k, 2);
      req = 4'b1111;
      repeat (12) step();
      check("t2_round_writes", 64'(n_wr), 64'd8);
      repeat (3) step();
      req = '0;
      check("t2_total_writes", 64'(n_wr), 64'd10);
      check("t2_idle_cycles", 64'(n_idle), 64'd5);
      check("t2_grant_count", 64'(glog_n), 64'd5);
      for (int i = 0; i < 5; i++) begin
         check("t2_grant_order", 64'(glog[i]), 64'(i % NR));
      end
      step();

      // FIFO full stalls the burst without losing words
      do_reset();
      set_len(1, 4);
      req = 4'b0010;
      step();
      step();
      full = 1'b1;
      step();
      step();
      #1;
      check("t3_stall_grant", 64'(grant), 64'b0010);
      check("t3_stall_busy", {63'd0, busy}, 64'd1);
      step();
      full = 1'b0;
      repeat (3) step();
      #1;
      check("t3_done_busy", {63'd0, busy}, 64'd0);
      check("t3_writes", 64'(wr_by[1]), 64'd4);
      check("t3_total", 64'(n_wr), 64'd4);
      req = '0;
      step();

      // Requester drops mid-burst; next grant moves past it
      do_reset();
      set_len(2, 8);
      req = 4'b0100;
      repeat (4) step();
      req = 4'b0000;
      #1;
      check("t4_abort_we", {63'd0, we}, 64'd0);
      step();
      #1;
      check("t4_idle", {63'd0, busy}, 64'd0);
      check("t4_writes", 64'(n_wr), 64'd3);
      set_len(3, 1);
      set_len(0, 1);
      req = 4'b1001;
      step();
      #1;
      check("t4_next_grant", 64'(grant), 64'b1000);
      step();
      req = '0;
      step();
      check("t4_r3_writes", 64'(wr_by[3]), 64'd1);
      check("t4_r0_writes", 64'(wr_by[0]), 64'd0);

      // Reset during the second word of a five-word burst
      do_reset();
      set_len(1, 5);
      set_len(2, 5);
      set_len(0, 1);
      req = 4'b0110;
      step();
      step();
      rst = 1'b1;
      #1;
      check("t5_rst_we", {63'd0, we}, 64'd0);
      check("t5_rst_ack", 64'(ack), 64'd0);
      step();
      rst = 1'b0;
      req = 4'b0011;
      #1;
      check("t5_post_grant", 64'(grant), 64'd0);
      check("t5_post_busy", {63'd0, busy}, 64'd0);
      check("t5_r1_writes", 64'(wr_by[1]), 64'd1);
      step();
      #1;
      check("t5_rearb_grant", 64'(grant), 64'b0001);
      step();
      req = '0;
      step();
      check("t5_r0_writes", 64'(wr_by[0]), 64'd1);

      // Length clamping: 0 -> 1 word, MaxBurst+5 -> MaxBurst words
      do_reset();
      set_len(0, 0);
      req = 4'b0001;
      step();
      step();
      set_len(1, MB + 5);
      req = 4'b0010;
      repeat (17) step();
      req = '0;
      #1;
      check("t6_idle", {63'd0, busy}, 64'd0);
      check("t6_len0_writes", 64'(wr_by[0]), 64'd1);
      check("t6_clamp_writes", 64'(wr_by[1]), 64'(MB));
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL take parameter NumReq, default 4; number of requesters sharing one FIFO write port (2..16).
REQ-002 SHALL take parameter DataWidth, default 32; width of each requester's data word and of the FIFO input.
REQ-003 SHALL take parameter MaxBurst, default 16; largest burst length in words; LenWidth = $clog2(MaxBurst+1).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port req_i  input  NumReq  per-requester request, level, held for the whole burst.
REQ-007 SHALL have port burst_len_i  input  NumReq*LenWidth  packed burst lengths, requester k at [k*LenWidth +: LenWidth].
REQ-008 SHALL have port data_i  input  NumReq*DataWidth  packed data words, requester k at [k*DataWidth +: DataWidth].
REQ-009 SHALL have port ack_o  input-side output  NumReq  one-hot; bit k high means requester k's current word is consumed this cycle.
REQ-010 SHALL have port grant_o  output  NumReq  one-hot registered grant; all zero when idle.
REQ-011 SHALL have port busy_o  output  1  high while in BURST.
REQ-012 SHALL have port fifo_full_i  input  1  full flag from the downstream FIFO.
REQ-013 SHALL have port fifo_write_en_o  output  1  write strobe to the FIFO.
REQ-014 SHALL have port fifo_data_o  output  DataWidth  write data to the FIFO.

Function
REQ-015 SHALL implement states IDLE and BURST.
REQ-016 IDLE: if any req_i bit is high, SHALL grant the first requesting index after last_grant (round-robin, wrapping NumReq-1 -> 0), latch its length into remaining, set grant_o, and enter BURST next cycle; no write in IDLE.
REQ-017 A latched burst_len of 0 SHALL be treated as 1; values above MaxBurst SHALL be clamped to MaxBurst.
REQ-018 BURST: fifo_write_en_o = req_i[g] & ~fifo_full_i (combinational), fifo_data_o = data word of granted g, ack_o = grant_o when fifo_write_en_o, else 0.
REQ-019 Each write SHALL decrement remaining by 1; the write with remaining == 1 SHALL return to IDLE next cycle, store g in last_grant, and clear grant_o.
REQ-020 fifo_full_i high in BURST SHALL stall: no write, no ack, remaining unchanged, grant held.
REQ-021 req_i[g] dropping in BURST SHALL abort: no write that cycle, return to IDLE, last_grant = g, remaining discarded.
REQ-022 Request changes of non-granted requesters during BURST SHALL have no effect until the next IDLE arbitration.
REQ-023 Minimum gap between bursts SHALL be one IDLE cycle; sustained throughput is one word per cycle inside a burst.
REQ-024 fifo_write_en_o SHALL never be high while fifo_full_i is high; ack_o SHALL never have more than one bit set.

Reset
REQ-025 On rst_i SHALL enter IDLE with grant_o = 0, busy_o = 0, remaining = 0, last_grant = NumReq-1 (requester 0 wins first).
REQ-026 Reset asserted mid-burst SHALL abandon the burst in the same edge; fifo_write_en_o and ack_o SHALL be 0 in every cycle where rst_i is high.
REQ-027 fifo_data_o SHALL be 0 whenever fifo_write_en_o is 0.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the clamp/length-width helper function.
REQ-029 Sub-module rr_picker SHALL be used: combinational round-robin priority encoder (inputs req vector, last index; outputs one-hot grant, index, any).
REQ-030 Downstream FIFO SHALL be instantiated outside this block; this block only drives its write side.

Verification
REQ-031 Reset, then req_i=4'b0001, len0=3, FIFO never full -> grant_o=0001 at cycle 1, three writes of data0 on cycles 1-3, IDLE at cycle 4.
REQ-032 req_i=4'b1111, all len=2 held -> grant order 0,1,2,3,0; 8 writes per round; one idle cycle between bursts.
REQ-033 Requester 1 len=4, fifo_full_i high for cycles 2-4 -> writes only on non-full cycles, exactly 4 writes total, grant held through stall.
REQ-034 Requester 2 len=8, req_i[2] dropped after 3 writes -> exactly 3 writes, IDLE next cycle, next grant to requester 3 when it requests.
REQ-035 rst_i asserted during 2nd word of a 5-word burst -> no write that cycle, grant_o=0, next arbitration favours requester 0.
REQ-036 len=0 and len=MaxBurst+5 on two requesters -> 1 word and MaxBurst words respectively.
